// File: rtl/posit8_mult_unpacked_pkg.sv
// Shared widths, field positions and the unpacked-result layout for the
// posit<8,0> multiplier datapath.
package posit_mult_pkg;

  localparam int POSIT8_W = 8;
  localparam int RESULT_W = 21;
  localparam int FRAC_W   = 13;
  localparam int EXP_W    = 5;
  localparam int K_W      = 4;
  localparam int DFRAC_W  = 5;

  localparam logic [EXP_W-1:0] EXP_BIAS = 5'd14;

  localparam int NAR_BIT  = 20;
  localparam int ZERO_BIT = 19;
  localparam int SIGN_BIT = 18;
  localparam int EXP_MSB  = 17;
  localparam int EXP_LSB  = 13;
  localparam int FRAC_MSB = 12;
  localparam int FRAC_LSB = 0;

  localparam logic [POSIT8_W-1:0] POSIT8_ZERO = 8'h00;
  localparam logic [POSIT8_W-1:0] POSIT8_NAR  = 8'h80;

  typedef struct packed {
    logic              nar;
    logic              zero;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } posit_result_t;

  localparam posit_result_t RESULT_ZERO = '{nar: 1'b0, zero: 1'b1, sign: 1'b0,
                                            exp: '0, frac: '0};
  localparam posit_result_t RESULT_NAR  = '{nar: 1'b1, zero: 1'b0, sign: 1'b0,
                                            exp: '0, frac: '0};

endpackage

// File: rtl/posit8_mult_unpacked_decode.sv
// Decodes one posit<8,0> into sign, special flags, regime value k and a
// 5-bit MSB-aligned fraction (hidden 1 not included).
module posit8_decode
  import posit_mult_pkg::*;
(
  input  logic [POSIT8_W-1:0] i_posit,
  output logic                o_sign,
  output logic                o_zero,
  output logic                o_nar,
  output logic [K_W-1:0]      o_k,
  output logic [DFRAC_W-1:0]  o_frac
);

  logic [6:0] w_abs;
  logic [2:0] w_run;
  logic       w_stop;
  logic       w_regime_bit;

  // Only the low 7 bits of the magnitude matter; the two's complement of
  // those depends on nothing above them.
  always_comb begin
    w_abs        = i_posit[7] ? (~i_posit[6:0] + 7'd1) : i_posit[6:0];
    w_regime_bit = w_abs[6];
    w_run        = 3'd0;
    w_stop       = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!w_stop && (w_abs[i] == w_regime_bit)) begin
        w_run = w_run + 3'd1;
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  assign o_sign = i_posit[7];
  assign o_zero = (i_posit == POSIT8_ZERO);
  assign o_nar  = (i_posit == POSIT8_NAR);

  assign o_k = w_regime_bit ? ({1'b0, w_run} - 4'd1) : (4'd0 - {1'b0, w_run});

  // The run is at least one bit long, so at most bits [4:0] remain after
  // the terminator; shifting by run-1 left-aligns whatever is left.
  assign o_frac = w_abs[4:0] << (w_run - 3'd1);

endmodule

// File: rtl/posit8_mult_unpacked.sv
// Registered exact multiplier of two posit<8,0> values into a 21-bit
// unpacked result. Optional POSIT_MULT_INPUT_REG_EN adds an input register.
module posit8_mult_unpacked
  import posit_mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [POSIT8_W-1:0] left_posit,
  input  logic [POSIT8_W-1:0] right_posit,
  output logic [RESULT_W-1:0] result
);

  logic [POSIT8_W-1:0] w_left;
  logic [POSIT8_W-1:0] w_right;

`ifdef POSIT_MULT_INPUT_REG_EN
  logic [POSIT8_W-1:0] r_left;
  logic [POSIT8_W-1:0] r_right;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_left  <= POSIT8_ZERO;
      r_right <= POSIT8_ZERO;
    end else begin
      r_left  <= left_posit;
      r_right <= right_posit;
    end
  end

  assign w_left  = r_left;
  assign w_right = r_right;
`else
  assign w_left  = left_posit;
  assign w_right = right_posit;
`endif

  logic               w_l_sign, w_l_zero, w_l_nar;
  logic               w_r_sign, w_r_zero, w_r_nar;
  logic [K_W-1:0]     w_l_k, w_r_k;
  logic [DFRAC_W-1:0] w_l_frac, w_r_frac;

  posit8_decode u_dec_left (
    .i_posit (w_left),
    .o_sign  (w_l_sign),
    .o_zero  (w_l_zero),
    .o_nar   (w_l_nar),
    .o_k     (w_l_k),
    .o_frac  (w_l_frac)
  );

  posit8_decode u_dec_right (
    .i_posit (w_right),
    .o_sign  (w_r_sign),
    .o_zero  (w_r_zero),
    .o_nar   (w_r_nar),
    .o_k     (w_r_k),
    .o_frac  (w_r_frac)
  );

  logic [11:0]       w_sig;
  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  posit_result_t     w_next;
  posit_result_t     r_result;

  // 1.f x 1.f with 10 fractional bits; bit 11 set means the product is >= 2.
  assign w_sig = {6'd0, 1'b1, w_l_frac} * {6'd0, 1'b1, w_r_frac};

  // Biased exponent always lands in 2..27, so modulo-32 arithmetic is exact.
  assign w_exp = {w_l_k[3], w_l_k} + {w_r_k[3], w_r_k} + {4'd0, w_sig[11]} + EXP_BIAS;

  assign w_frac = w_sig[11] ? {w_sig[10:0], 2'b00} : {w_sig[9:0], 3'b000};

  always_comb begin
    w_next = '{nar: 1'b0, zero: 1'b0, sign: w_l_sign ^ w_r_sign,
               exp: w_exp, frac: w_frac};
    if (w_l_nar || w_r_nar) begin
      w_next = RESULT_NAR;
    end else if (w_l_zero || w_r_zero) begin
      w_next = RESULT_ZERO;
    end
  end

  // No handshake: every edge captures a new product, one result per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_result <= RESULT_ZERO;
    end else begin
      r_result <= w_next;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_posit8_mult_unpacked.sv
// Directed, table-driven bench for posit8_mult_unpacked with hand-computed
// expected products, streamed back-to-back plus reset corner sequences.
module tb_posit8_mult_unpacked;

`ifdef POSIT_MULT_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [20:0] ZERO_R = 21'h080000;
  localparam logic [20:0] NAR_R  = 21'h100000;

  logic        clk;
  logic        rst;
  logic [7:0]  left_posit;
  logic [7:0]  right_posit;
  logic [20:0] result;

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];

  typedef struct {
    logic [7:0]  l;
    logic [7:0]  r;
    logic [20:0] want;
  } vec_t;

  vec_t vecs[18];

  posit8_mult_unpacked dut (
    .clk         (clk),
    .rst         (rst),
    .left_posit  (left_posit),
    .right_posit (right_posit),
    .result      (result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] l, input logic [7:0] r);
    left_posit  = l;
    right_posit = r;
  endtask

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, got, want);
    end
  endtask

  initial begin
    vecs[0]  = '{8'h20, 8'h60, 21'h01C000};
    vecs[1]  = '{8'h66, 8'hDB, 21'h05D2E0};
    vecs[2]  = '{8'h8F, 8'h3A, 21'h0600A0};
    vecs[3]  = '{8'hB2, 8'hE2, 21'h01AB20};
    vecs[4]  = '{8'h00, 8'h66, ZERO_R};
    vecs[5]  = '{8'h80, 8'h3A, NAR_R};
    vecs[6]  = '{8'h80, 8'h00, NAR_R};
    vecs[7]  = '{8'h3A, 8'h80, NAR_R};
    vecs[8]  = '{8'h66, 8'h00, ZERO_R};
    vecs[9]  = '{8'h7F, 8'h7F, 21'h034000};
    vecs[10] = '{8'h01, 8'h01, 21'h004000};
    vecs[11] = '{8'h7F, 8'h81, 21'h074000};
    vecs[12] = '{8'h7F, 8'hFF, 21'h05C000};
    vecs[13] = '{8'h40, 8'h40, 21'h01C000};
    vecs[14] = '{8'h50, 8'h50, 21'h01E400};
    vecs[15] = '{8'hC0, 8'h40, 21'h05C000};
    vecs[16] = '{8'h01, 8'h7F, 21'h01C000};
    vecs[17] = '{8'hFF, 8'hFF, 21'h004000};

    // reset held while 0x20 x 0x60 is presented: operands discarded
    rst = 1'b0;
    drive(8'h20, 8'h60);
    @(negedge clk);
    check("reset_state", result, ZERO_R);
    rst = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check("reset_input_reg_zero", result, ZERO_R);
    end
    @(negedge clk);
    check("first_after_reset_0x20x0x60", result, 21'h01C000);

    // back-to-back stream of the whole table
    for (int i = 0; i < $size(vecs) + LAT; i++) begin
      if (i >= LAT) begin
        check($sformatf("vec%0d_%02h_x_%02h", i - LAT, vecs[i - LAT].l, vecs[i - LAT].r),
              result, exp_q.pop_front());
      end
      if (i < $size(vecs)) begin
        drive(vecs[i].l, vecs[i].r);
        exp_q.push_back(vecs[i].want);
      end else begin
        drive(8'h40, 8'h40);
      end
      @(negedge clk);
    end

    // mid-stream reset: nonzero result cleared, operands at the reset edge lost
    drive(8'h66, 8'hDB);
    repeat (LAT) @(negedge clk);
    check("pre_reset_value", result, 21'h05D2E0);
    rst = 1'b0;
    drive(8'h8F, 8'h3A);
    @(negedge clk);
    check("mid_stream_reset", result, ZERO_R);
    rst = 1'b1;
    drive(8'hB2, 8'hE2);
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check("mid_reset_input_reg_zero", result, ZERO_R);
    end
    @(negedge clk);
    check("first_after_mid_reset", result, 21'h01AB20);

    // independent capture: result tracks each new operand pair exactly LAT edges later
    drive(8'h8F, 8'h3A);
    @(negedge clk);
    drive(8'h80, 8'h00);
    if (LAT == 2) check("lat2_hold_previous", result, 21'h01AB20);
    else          check("lat1_next_value", result, 21'h0600A0);
    @(negedge clk);
    if (LAT == 2) check("lat2_delayed_value", result, 21'h0600A0);
    else          check("lat1_nar_value", result, NAR_R);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
